// File: rtl/instr_issue_buffer.sv
// ============================================================================
// Module   : instr_issue_buffer
// Purpose  : Circular FIFO of fetched instruction pairs with in-order dual
//            issue to decode, branch flush and freeze. Optional build macro
//            IBUF_STATS_EN adds issued_count / stall_count ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_issue_buffer #(
  parameter int WORD  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_pc,
  input  logic [WORD-1:0] in_instr1,
  input  logic [WORD-1:0] in_instr2,
  input  logic            in_slot1_valid,
  input  logic            branch_taken,
  input  logic            stop_and_signal,
  input  logic            dep_stall_instr1,
  input  logic            dep_stall_instr2,
  output logic [WORD-1:0] out_pc,
  output logic [WORD-1:0] out_instr1,
  output logic [WORD-1:0] out_instr2,
`ifdef IBUF_STATS_EN
  output logic [31:0]     issued_count,
  output logic [31:0]     stall_count,
`endif
  output logic            out_valid1,
  output logic            out_valid2
);

  localparam int            c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic [WORD-1:0] c_NOP  = WORD'(32'h0020_0000);

  logic [WORD-1:0] r_pc     [DEPTH];
  logic [WORD-1:0] r_instr1 [DEPTH];
  logic [WORD-1:0] r_instr2 [DEPTH];
  logic [DEPTH-1:0] r_v1;
  logic [DEPTH-1:0] r_v2;
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;

  logic w_empty, w_hold, w_hv1, w_hv2, w_clr1;
  logic w_iss1, w_iss2, w_pop, w_part, w_push;

  assign w_empty = (r_count == '0);
  assign w_hold  = stop_and_signal | branch_taken;
  assign w_hv1   = ~w_empty & r_v1[r_rd_ptr];
  assign w_hv2   = ~w_empty & r_v2[r_rd_ptr];

  // Slot1 is out of the way when it was already issued/padding or issues now.
  assign w_clr1  = ~w_hv1 | ~dep_stall_instr1;
  assign w_iss1  = ~w_hold & w_hv1 & ~dep_stall_instr1;
  assign w_iss2  = ~w_hold & w_clr1 & w_hv2 & ~dep_stall_instr2;
  assign w_pop   = ~w_hold & ~w_empty & w_clr1 & (~w_hv2 | ~dep_stall_instr2);
  assign w_part  = ~w_hold & ~w_empty & w_clr1 & w_hv2 & dep_stall_instr2;

  assign in_ready = (r_count < c_FULL) & ~w_hold;
  assign w_push   = in_valid & in_ready;

  assign out_valid1 = w_hv1 & ~w_hold;
  assign out_valid2 = w_hv2 & ~w_hold;
  assign out_pc     = w_empty ? '0 : r_pc[r_rd_ptr];
  assign out_instr1 = w_hv1 ? r_instr1[r_rd_ptr] : c_NOP;
  assign out_instr2 = w_hv2 ? r_instr2[r_rd_ptr] : c_NOP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_v1     <= '0;
      r_v2     <= '0;
    end else if (branch_taken) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_v1[r_wr_ptr] <= in_slot1_valid;
        r_v2[r_wr_ptr] <= 1'b1;
        r_wr_ptr       <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      // A push never lands on the head slot here: that would need a full buffer.
      if (w_part) begin
        r_v1[r_rd_ptr] <= 1'b0;
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]     <= in_pc;
      r_instr1[r_wr_ptr] <= in_instr1;
      r_instr2[r_wr_ptr] <= in_instr2;
    end
  end

`ifdef IBUF_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_count <= '0;
      stall_count  <= '0;
    end else begin
      issued_count <= issued_count + 32'(w_iss1) + 32'(w_iss2);
      if ((out_valid1 | out_valid2) & ~w_iss1 & ~w_iss2) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_issue_buffer.sv
// ============================================================================
// Module   : tb_instr_issue_buffer
// Purpose  : Directed plus random stimulus checked against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_issue_buffer;

  localparam int          c_DEPTH = 4;
  localparam logic [31:0] c_NOP   = 32'h0020_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        v1;
    logic        v2;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_slot1_valid;
  logic [31:0] in_pc, in_instr1, in_instr2;
  logic        branch_taken, stop_and_signal, dep_stall_instr1, dep_stall_instr2;
  logic [31:0] out_pc, out_instr1, out_instr2;
  logic        out_valid1, out_valid2;
`ifdef IBUF_STATS_EN
  logic [31:0] issued_count, stall_count;
`endif

  ent_t        m_q[$];
  logic [31:0] m_issued, m_stall;
  int          n_total = 0;
  int          n_bad   = 0;

  instr_issue_buffer #(.WORD(32), .DEPTH(c_DEPTH)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_pc            (in_pc),
    .in_instr1        (in_instr1),
    .in_instr2        (in_instr2),
    .in_slot1_valid   (in_slot1_valid),
    .branch_taken     (branch_taken),
    .stop_and_signal  (stop_and_signal),
    .dep_stall_instr1 (dep_stall_instr1),
    .dep_stall_instr2 (dep_stall_instr2),
    .out_pc           (out_pc),
    .out_instr1       (out_instr1),
    .out_instr2       (out_instr2),
`ifdef IBUF_STATS_EN
    .issued_count     (issued_count),
    .stall_count      (stall_count),
`endif
    .out_valid1       (out_valid1),
    .out_valid2       (out_valid2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs follow directly from the queue head and the current inputs.
  task automatic check_outs(input string tag);
    ent_t h;
    bit   have = (m_q.size() > 0);
    bit   hold = branch_taken | stop_and_signal;
    h = have ? m_q[0] : '0;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'((m_q.size() < c_DEPTH) && !hold));
    chk({tag, ".out_valid1"}, 64'(out_valid1), 64'(have && h.v1 && !hold));
    chk({tag, ".out_valid2"}, 64'(out_valid2), 64'(have && h.v2 && !hold));
    chk({tag, ".out_pc"}, 64'(out_pc), 64'(have ? h.pc : 32'h0));
    chk({tag, ".out_instr1"}, 64'(out_instr1), 64'((have && h.v1) ? h.i1 : c_NOP));
    chk({tag, ".out_instr2"}, 64'(out_instr2), 64'((have && h.v2) ? h.i2 : c_NOP));
`ifdef IBUF_STATS_EN
    chk({tag, ".issued_count"}, 64'(issued_count), 64'(m_issued));
    chk({tag, ".stall_count"}, 64'(stall_count), 64'(m_stall));
`endif
  endtask

  task automatic step(input string tag, input logic inv, input logic [31:0] pc,
                      input logic s1v, input logic br, input logic stp,
                      input logic d1, input logic d2);
    ent_t h, e;
    bit   have, rdy, s1clr, iss1, iss2;
    in_valid         = inv;
    in_pc            = pc;
    in_instr1        = $urandom;
    in_instr2        = $urandom;
    in_slot1_valid   = s1v;
    branch_taken     = br;
    stop_and_signal  = stp;
    dep_stall_instr1 = d1;
    dep_stall_instr2 = d2;
    @(negedge clk);
    check_outs(tag);
    have = (m_q.size() > 0);
    rdy  = (m_q.size() < c_DEPTH) && !br && !stp;
    @(posedge clk);
    if (br) begin
      m_q.delete();
    end else if (!stp) begin
      if (have) begin
        h     = m_q[0];
        s1clr = !h.v1 || !d1;
        iss1  = h.v1 && !d1;
        iss2  = s1clr && h.v2 && !d2;
        m_issued = m_issued + 32'(iss1) + 32'(iss2);
        if ((h.v1 || h.v2) && !iss1 && !iss2) m_stall = m_stall + 1;
        if (s1clr && (!h.v2 || !d2)) begin
          void'(m_q.pop_front());
        end else if (s1clr) begin
          h.v1   = 1'b0;
          m_q[0] = h;
        end
      end
      if (inv && rdy) begin
        e = '{pc: pc, i1: in_instr1, i2: in_instr2, v1: s1v, v2: 1'b1};
        m_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    in_valid = 1'b0; branch_taken = 1'b0; stop_and_signal = 1'b0;
    dep_stall_instr1 = 1'b0; dep_stall_instr2 = 1'b0;
    #2 reset = 1'b1;
    m_q.delete();
    m_issued = 0;
    m_stall  = 0;
    #1 check_outs(tag);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_instr1 = '0; in_instr2 = '0; in_slot1_valid = 1'b1;
    branch_taken = 1'b0; stop_and_signal = 1'b0;
    dep_stall_instr1 = 1'b0; dep_stall_instr2 = 1'b0;
    m_issued = 0;
    m_stall  = 0;
    #2 check_outs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back pairs with no stalls
    step("seq", 1'b1, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("seq", 1'b1, 32'h8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("seq", 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("seq_drain", 2);

    // Fill under slot1 stall, fifth pair refused, then drain
    for (int k = 0; k < 5; k++)
      step("full", 1'b1, 32'h40 + 32'(k * 8), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("full_stop", 1'b1, 32'h99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("full_drain", 5);

    // Slot2 stall for one cycle splits the pair
    step("split", 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("split", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("split", 2);

    // Odd-start fetch leaves slot1 as padding
    step("odd", 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("odd", 2);

    // Flush with three held and a concurrent push
    for (int k = 0; k < 3; k++)
      step("flush_fill", 1'b1, 32'h100 + 32'(k * 8), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("flush", 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("flush_after", 2);

    // Asynchronous reset with two pairs held
    for (int k = 0; k < 2; k++)
      step("rst_fill", 1'b1, 32'h300 + 32'(k * 8), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    async_reset("async_rst");
    idle("post_rst", 2);

    for (int k = 0; k < 400; k++) begin
      step("rand", ($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFF8,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0));
      if (k == 200) async_reset("rand_rst");
    end
    idle("final", 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_issue_buffer.md
INSTR_ISSUE_BUFFER -- requirements
Module: instr_issue_buffer

Interface
REQ-001 Parameter WORD, default 32, instruction and PC width in bits.
REQ-002 Parameter DEPTH, default 4, number of instruction-pair entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  fetch presents a pair this cycle.
REQ-006 in_ready  output  1  buffer accepts a pair this cycle.
REQ-007 in_pc  input  WORD  address of the pair (of in_instr1 slot).
REQ-008 in_instr1, in_instr2  input  WORD each  even and odd slot instructions.
REQ-009 in_slot1_valid  input  1  0 when fetch started at an odd word (slot1 is padding).
REQ-010 branch_taken  input  1  flush request from branch resolution.
REQ-011 stop_and_signal  input  1  freeze request.
REQ-012 dep_stall_instr1, dep_stall_instr2  input  1 each  decode cannot accept slot1 / slot2 this cycle.
REQ-013 out_pc  output  WORD  head entry PC.
REQ-014 out_instr1, out_instr2  output  WORD each  head instructions presented to decode.
REQ-015 out_valid1, out_valid2  output  1 each  head slot holds an unissued real instruction.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH entries {pc, instr1, instr2, v1, v2}, with wr_ptr, rd_ptr and count (0..DEPTH), pointers wrapping modulo DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH) and not stop_and_signal and not branch_taken.
REQ-018 Push SHALL occur when in_valid and in_ready; the entry stores v1 = in_slot1_valid, v2 = 1.
REQ-019 When the buffer is empty, out_valid1 = out_valid2 = 0; pushed data is visible at the outputs no earlier than the cycle after the push (1-cycle latency, no bypass).
REQ-020 A slot with v = 0 SHALL drive instruction 32'h00200000 (NOP) on its out_instr port.
REQ-021 Issue is in order: slot2 issues only when slot1 is issued or invalid.
REQ-022 If head v1 = 1 and dep_stall_instr1 = 1, nothing issues and the entry is held.
REQ-023 If slot1 issues (or v1 = 0) and dep_stall_instr2 = 1, head v1 clears and the entry stays; slot2 is re-presented next cycle.
REQ-024 If both slots are clear to issue, the entry is popped (rd_ptr+1, count-1).
REQ-025 Push and pop in the same cycle SHALL leave count unchanged.
REQ-026 branch_taken = 1 SHALL, at the clock edge, set count = 0 and rd_ptr = wr_ptr = 0; a concurrent push is dropped, a concurrent pop is discarded, and out_valid1/2 are forced to 0 in that cycle.
REQ-027 stop_and_signal = 1 (without branch_taken) SHALL hold all state, force out_valid1/2 = 0, and block push; branch_taken has priority over stop_and_signal.

Reset
REQ-028 On reset assertion, count, rd_ptr and wr_ptr SHALL be 0 and all entry v1/v2 bits cleared, immediately and independent of clk.
REQ-029 During and after reset: in_ready = 1 (unless stop_and_signal or branch_taken), out_valid1 = out_valid2 = 0, out_instr1 = out_instr2 = NOP, out_pc = 0.
REQ-030 Reset asserted mid-operation SHALL discard all held pairs; no partial issue state survives.

Configuration
REQ-031 Macro IBUF_STATS_EN: when defined, SHALL add output ports issued_count (32 bits, +1 or +2 per cycle per slot issued) and stall_count (32 bits, +1 per cycle with out_valid1 or out_valid2 = 1 and no slot issued), both zeroed by reset and wrapping at 2^32; when undefined, these ports and counters SHALL NOT exist and behaviour is otherwise identical.

Verification
REQ-032 Push pairs at PC 0x0, 0x8, 0x10, no stalls -> issued at outputs on cycles 1, 2, 3 with out_valid1 = out_valid2 = 1, count returns to 0.
REQ-033 Push 4 pairs with dep_stall_instr1 = 1 -> count = 4, in_ready = 0, 5th pair not accepted; release stall -> pairs drain in order.
REQ-034 Head pair at 0x20, dep_stall_instr2 = 1 for one cycle -> cycle N: slot1 issues; cycle N+1: out_valid1 = 0, out_instr1 = 0x00200000, out_valid2 = 1; then pop.
REQ-035 Push with in_slot1_valid = 0 at PC 0x4 -> out_valid1 = 0, out_instr1 = 0x00200000, out_valid2 = 1.
REQ-036 3 entries held, branch_taken and in_valid both high -> next cycle count = 0, out_valid1/2 = 0, incoming pair absent.
REQ-037 Assert reset asynchronously between clk edges with 2 entries held -> outputs reach reset values before next edge; with IBUF_STATS_EN, issued_count = stall_count = 0.
